// File: rtl/button_debounce.sv
// button_debounce: synchronised, bounce-filtered push-button input with
// press/release/long-press pulses and a wrapping press counter.
module button_debounce #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   level,
  output logic                   press,
  output logic                   release_pulse,
  output logic                   long_press,
  output logic [COUNT_WIDTH-1:0] press_count
);
  localparam int FW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  logic                   s1_q, s2_q;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic [FW-1:0]          flt_q, flt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  state_t                 state_q, state_d;
  // any sample that agrees with the current level restarts the stability count
  always_comb begin
    flt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (flt_q == FW'(STABLE_CYCLES - 1)) level_d = s2_q;
      else flt_d = flt_q + FW'(1);
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    count_d   = count_q + COUNT_WIDTH'(press_d);
  end
  // a release on the threshold cycle takes priority over long_press
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d = HELD;
          hold_d  = '0;
        end
      end
      HELD: begin
        if (release_d) state_d = IDLE;
        else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          state_d = LONG;
        end else hold_d = hold_q + HW'(1);
      end
      LONG: state_d = release_d ? IDLE : LONG;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      flt_q     <= '0;
      hold_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
    end else begin
      s1_q      <= btn_in ^ ACTIVE_LOW;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      flt_q     <= flt_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end
  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign press_count   = count_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and randomised pin stimulus checked against a
// sample-history reference model of the debouncer.
module tb_button_debounce;
  localparam int S = 4;
  localparam int L = 20;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       level, press, release_pulse, long_press;
  logic [3:0] press_count;
  int passes = 0;
  int fails = 0;
  bit m_s1, m_s2, m_level, m_press, m_rel, m_long;
  bit hist[$];
  int m_cnt = 0;
  int t = 0;
  int last_press = -1000;
  int n_press, n_rel, n_long, tp, tr, n, v, len;
  bit pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  always #5 clk = ~clk;

  button_debounce #(.STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .press_count(press_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock with pin b and reset r; the model keeps the synchronised
  // samples that disagree with the level since the last change or restart
  task automatic step(input bit b, input bit r);
    bit chg;
    btn_in = b;
    rst = r;
    @(posedge clk);
    t++;
    chg = 1'b0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      m_cnt = 0; last_press = -1000; hist.delete();
    end else begin
      if (m_s2 == m_level) hist.delete();
      else hist.push_back(m_s2);
      if (hist.size() == S) begin
        chg = 1'b1;
        m_level = ~m_level;
        hist.delete();
      end
      m_s2 = m_s1;
      m_s1 = b;
      m_press = chg && m_level;
      m_rel = chg && !m_level;
      if (m_press) begin
        m_cnt = (m_cnt + 1) % 16;
        last_press = t;
      end
      m_long = m_level && (t - last_press == L);
    end
    #1;
    chk("level", level, m_level);
    chk("press", press, m_press);
    chk("release", release_pulse, m_rel);
    chk("long_press", long_press, m_long);
    chk("press_count", press_count, m_cnt);
    chk("press_release_exclusive", press & release_pulse, 0);
    if (press === 1'b1) begin n_press++; tp = t; end
    if (release_pulse === 1'b1) begin n_rel++; tr = t; end
    if (long_press === 1'b1) n_long++;
  endtask

  initial begin
    repeat (3) step(0, 1);
    repeat (10) step(0, 0);
    chk("idle_count", press_count, 0);
    chk("idle_level", level, 0);
    n_press = 0; n_rel = 0; n_long = 0;
    repeat (30) step(1, 0);
    chk("clean_presses", n_press, 1);
    chk("clean_long", n_long, 1);
    chk("clean_count", press_count, 1);
    repeat (10) step(0, 0);
    n_press = 0; n_rel = 0; n_long = 0;
    foreach (pat[i]) step(pat[i], 0);
    repeat (6) step(1, 0);
    chk("bounce_presses", n_press, 1);
    chk("bounce_releases", n_rel, 0);
    repeat (12) step(0, 0);
    n_press = 0; n_rel = 0; n_long = 0;
    repeat (10) step(1, 0);
    repeat (15) step(0, 0);
    chk("short_presses", n_press, 1);
    chk("short_releases", n_rel, 1);
    chk("short_long", n_long, 0);
    chk("short_width", tr - tp, 10);
    repeat (17) begin
      repeat (7) step(1, 0);
      repeat (7) step(0, 0);
    end
    chk("wrap_count", press_count, 4);
    repeat (40) begin
      v = $urandom_range(0, 1);
      len = $urandom_range(1, 30);
      repeat (len) step(v[0], 0);
      if ($urandom_range(0, 19) == 0) step(v[0], 1);
    end
    repeat (12) step(0, 0);
    repeat (10) step(1, 0);
    step(1, 1);
    chk("rst_level", level, 0);
    chk("rst_count", press_count, 0);
    n = 0;
    do begin
      step(1, 0);
      n++;
    end while (press !== 1'b1 && n < 20);
    chk("rst_press_edge", n, 6);
    chk("rst_press_count", press_count, 1);
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the LED blinker: reads one asynchronous push-button/switch pin instead of driving a pin.
- Synchronises the pin, filters contact bounce, and emits a clean level plus single-cycle press/release/long-press events.
- Keeps a wrapping press counter for status registers.
- Sits at board top level between the pin and fabric logic (mode select, manual trigger, LED demo).

Parameters:
- STABLE_CYCLES, 1000000, consecutive synchronised samples that must differ from current level before level changes (>=1).
- LONG_CYCLES, 50000000, cycles the debounced level must stay pressed before long_press fires (>=1).
- ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; inverted before the synchroniser.
- COUNT_WIDTH, 16, width of press_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous pin.
- level  output  1  debounced state, 1 = pressed.
- press  output  1  one-cycle pulse on debounced 0->1.
- release  output  1  one-cycle pulse on debounced 1->0.
- long_press  output  1  one-cycle pulse when held LONG_CYCLES.
- press_count  output  COUNT_WIDTH  number of presses, wraps.

Behaviour:
- Polarity: p = btn_in XOR ACTIVE_LOW, so p = 1 means pressed.
- Synchroniser:
  - Two flops, s1 <= p, s2 <= s1.
  - On reset both load 0 (released).
  - s2 is the only signal the filter reads.
- Filter counter (width clog2(STABLE_CYCLES+1)):
  - If s2 == level: counter <= 0.
  - Else if counter == STABLE_CYCLES-1: level <= s2, counter <= 0.
  - Else: counter <= counter+1.
- Any single sample equal to level restarts the count. This is the bounce rejection.
- Latency: a clean pin step registered at edge k gives s2 at edge k+1 and level at edge k+STABLE_CYCLES+1. Verification counts from the first edge s1 holds the new value.
- press / release:
  - Asserted in the same cycle level changes (registered alongside level).
  - Exactly one cycle wide.
  - Never both high in the same cycle.
- press_count:
  - Increments on the cycle press asserts.
  - All-ones wraps to 0 with no flag.
- Hold state machine:
  - IDLE: level == 0.
    - On press, go to HELD with hold counter = 0.
  - HELD: hold counter increments each cycle level == 1.
    - When the counter reaches LONG_CYCLES-1, long_press pulses for one cycle and the machine goes to LONG.
    - On release, go to IDLE with no long_press.
  - LONG: no further long_press while held.
    - On release, go to IDLE.
  - Release and the long-press threshold in the same cycle: release wins, no long_press, state goes to IDLE.
- Reset values:
  - level, press, release, long_press = 0.
  - press_count = 0.
  - Filter and hold counters = 0; state = IDLE.
- Reset mid-operation: all state clears next edge. A pin held pressed across reset produces a fresh press STABLE_CYCLES+2 edges after rst deasserts.
- No combinational path from btn_in to any output.

Test Plan (STABLE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0, COUNT_WIDTH=4):
- Reset, then idle 10 cycles:
  - level = press = release = long_press = 0, press_count = 0.
- Clean press, btn_in 0->1 held 30 cycles:
  - level rises on the 6th edge after the input edge, with press for 1 cycle, press_count = 1.
  - long_press fires exactly 20 cycles after press, once.
- Bounce: btn_in toggles 1,0,1,1,0,1,1,1,1,1 every cycle:
  - Exactly one press, only after 4 consecutive synchronised 1s.
  - No release.
- Short press, held 10 cycles then released:
  - press, then release 10 cycles later.
  - No long_press; state back to IDLE.
- Wrap: 17 clean press/release pairs:
  - press_count goes 15 -> 0 -> 1.
- Reset asserted while HELD, btn_in still 1:
  - Outputs clear next edge.
  - New press 6 edges after rst deasserts; press_count = 1.
